mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the EX/MEM pipeline register; feeds the MEM/WB register.
//  Non-memory ops: passes the ALU result (op_c) through to writeback unchanged.

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage between EX/MEM and MEM/WB: ALU pass-through, or a req/gnt/rvalid
// bus transaction with store lane alignment and load extraction. Optional: MEM_MISALIGN_CHK_EN.
module mem_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     ex_mem_reg_op_c_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_reg_reg_waddr_i,
  input  logic                  ex_mem_reg_reg_we_i,
  input  logic                  ex_mem_reg_mem_req_i,
  input  logic                  ex_mem_reg_mem_we_i,
  input  logic [1:0]            ex_mem_reg_mem_size_i,
  input  logic                  ex_mem_reg_mem_uns_i,
  input  logic [DATA_W-1:0]     ex_mem_reg_mem_wdata_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [DATA_W-1:0]     data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_W-1:0]     data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_W-1:0]     data_rdata_i,
  output logic [DATA_W-1:0]     mem_reg_wdata_o,
  output logic [REG_ADDR_W-1:0] mem_reg_waddr_o,
  output logic                  mem_reg_we_o,
  output logic                  mem_stall_o,
  output logic                  mem_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          addr_lsb;
  logic [1:0]          lane_off;
  logic                misalign;
  logic [DATA_W-1:0]   rdata_sh;
  logic [DATA_W-1:0]   load_data;

  assign addr_lsb = ex_mem_reg_op_c_i[1:0];

  // Lane offset forces the bits a half/word access cannot legally use to zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    lane_off = 2'b00;
    case (ex_mem_reg_mem_size_i)
      2'b00:   lane_off = addr_lsb;
      2'b01:   lane_off = {addr_lsb[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = ex_mem_reg_mem_req_i &
                    (((ex_mem_reg_mem_size_i == 2'b01) && addr_lsb[0]) ||
                     (ex_mem_reg_mem_size_i[1] && (addr_lsb != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Bus fields follow EX/MEM directly; EX/MEM is frozen while stalled, so they stay stable.
  assign data_addr_o = {ex_mem_reg_op_c_i[DATA_W-1:2], 2'b00};
  assign data_we_o   = ex_mem_reg_mem_we_i;

  always_comb begin
    data_be_o    = 4'hF;
    data_wdata_o = ex_mem_reg_mem_wdata_i;
    case (ex_mem_reg_mem_size_i)
      2'b00: begin
        data_be_o    = 4'b0001 << lane_off;
        data_wdata_o = {4{ex_mem_reg_mem_wdata_i[7:0]}};
      end
      2'b01: begin
        data_be_o    = 4'b0011 << lane_off;
        data_wdata_o = {2{ex_mem_reg_mem_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rdata_sh = data_rdata_i >> {lane_off, 3'b000};

  always_comb begin
    load_data = rdata_sh;
    case (ex_mem_reg_mem_size_i)
      2'b00:   load_data = {{24{~ex_mem_reg_mem_uns_i & rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_data = {{16{~ex_mem_reg_mem_uns_i & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_data = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign mem_reg_waddr_o = ex_mem_reg_reg_waddr_i;

  always_comb begin
    state_d         = state_q;
    data_req_o      = 1'b0;
    mem_stall_o     = 1'b0;
    mem_reg_we_o    = 1'b0;
    mem_reg_wdata_o = ex_mem_reg_op_c_i;
    mem_misalign_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ex_mem_reg_mem_req_i) begin
          mem_reg_we_o = ex_mem_reg_reg_we_i;
        end else if (misalign) begin
          mem_misalign_o = 1'b1;
        end else begin
          data_req_o = 1'b1;
          if (data_gnt_i && ex_mem_reg_mem_we_i) begin
            state_d = IDLE;
          end else begin
            mem_stall_o = 1'b1;
            state_d     = data_gnt_i ? RESP : REQ;
          end
        end
      end
      REQ: begin
        data_req_o  = 1'b1;
        mem_stall_o = 1'b1;
        if (data_gnt_i) begin
          if (ex_mem_reg_mem_we_i) begin
            mem_stall_o = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        mem_stall_o = 1'b1;
        if (data_rvalid_i) begin
          mem_stall_o     = 1'b0;
          mem_reg_we_o    = ex_mem_reg_reg_we_i;
          mem_reg_wdata_o = load_data;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, loads, stores, gnt/rvalid
// timing, misalignment handling and reset mid-transaction.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_c;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_uns;
  logic [31:0] mem_wdata;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic        stall;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  mem_stage dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ex_mem_reg_op_c_i      (op_c),
    .ex_mem_reg_reg_waddr_i (reg_waddr),
    .ex_mem_reg_reg_we_i    (reg_we),
    .ex_mem_reg_mem_req_i   (mem_req),
    .ex_mem_reg_mem_we_i    (mem_we),
    .ex_mem_reg_mem_size_i  (mem_size),
    .ex_mem_reg_mem_uns_i   (mem_uns),
    .ex_mem_reg_mem_wdata_i (mem_wdata),
    .data_req_o             (data_req),
    .data_gnt_i             (data_gnt),
    .data_addr_o            (data_addr),
    .data_we_o              (data_we),
    .data_be_o              (data_be),
    .data_wdata_o           (data_wdata),
    .data_rvalid_i          (data_rvalid),
    .data_rdata_i           (data_rdata),
    .mem_reg_wdata_o        (wb_wdata),
    .mem_reg_waddr_o        (wb_waddr),
    .mem_reg_we_o           (wb_we),
    .mem_stall_o            (stall),
    .mem_misalign_o         (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    op_c = 0; reg_waddr = 0; reg_we = 0; mem_req = 0; mem_we = 0;
    mem_size = 0; mem_uns = 0; mem_wdata = 0; data_gnt = 0; data_rvalid = 0; data_rdata = 0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input int gnt_dly, input int resp_dly,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp);
    op_c = addr; reg_waddr = 5'd9; reg_we = 1; mem_req = 1; mem_we = 0;
    mem_size = size; mem_uns = uns; data_gnt = 0; data_rvalid = 0;
    for (int i = 0; i < gnt_dly; i++) begin
      #2;
      check({tag, "_wait_req"}, 32'(data_req), 32'd1);
      check({tag, "_wait_stall"}, 32'(stall), 32'd1);
      tick();
    end
    data_gnt = 1;
    #2;
    check({tag, "_gnt_req"}, 32'(data_req), 32'd1);
    check({tag, "_addr"}, data_addr, exp_addr);
    check({tag, "_we"}, 32'(data_we), 32'd0);
    check({tag, "_gnt_stall"}, 32'(stall), 32'd1);
    check({tag, "_gnt_wbwe"}, 32'(wb_we), 32'd0);
    tick();
    data_gnt = 0;
    for (int i = 0; i < resp_dly; i++) begin
      #2;
      check({tag, "_resp_req"}, 32'(data_req), 32'd0);
      check({tag, "_resp_stall"}, 32'(stall), 32'd1);
      check({tag, "_resp_wbwe"}, 32'(wb_we), 32'd0);
      tick();
    end
    data_rvalid = 1; data_rdata = rdata;
    #2;
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_done_wbwe"}, 32'(wb_we), 32'd1);
    check({tag, "_data"}, wb_wdata, exp);
    check({tag, "_waddr"}, 32'(wb_waddr), 32'd9);
    tick();
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #2;
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_wbwe", 32'(wb_we), 32'd0);
    check("rst_wbdata", wb_wdata, 32'd0);
    check("rst_wbaddr", 32'(wb_waddr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // ALU pass-through, with spurious gnt/rvalid ignored in IDLE
    op_c = 32'h1234; reg_waddr = 5; reg_we = 1; data_gnt = 1; data_rvalid = 1;
    data_rdata = 32'hFFFF_FFFF;
    #2;
    check("alu_wdata", wb_wdata, 32'h1234);
    check("alu_waddr", 32'(wb_waddr), 32'd5);
    check("alu_we", 32'(wb_we), 32'd1);
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_req", 32'(data_req), 32'd0);
    tick();
    clear_inputs();

    // loads: lw with 2 idle response cycles, byte/half extraction, delayed grant
    do_load("lw", 32'h100, 2'b10, 0, 0, 2, 32'hDEAD_BEEF, 32'h100, 32'hDEAD_BEEF);
    do_load("lb", 32'h103, 2'b00, 0, 0, 1, 32'h80FF_FFFF, 32'h100, 32'hFFFF_FF80);
    do_load("lbu", 32'h103, 2'b00, 1, 0, 1, 32'h80FF_FFFF, 32'h100, 32'h0000_0080);
    do_load("lh", 32'h402, 2'b01, 0, 2, 1, 32'h80FF_1234, 32'h400, 32'hFFFF_80FF);
    do_load("lhu", 32'h400, 2'b01, 1, 1, 0, 32'h1234_8001, 32'h400, 32'h0000_8001);
    do_load("lb1", 32'h501, 2'b00, 0, 0, 1, 32'h1122_7F44, 32'h500, 32'h0000_007F);

    // sh with grant withheld 3 cycles
    op_c = 32'h202; mem_wdata = 32'h0000_ABCD; mem_req = 1; mem_we = 1;
    mem_size = 2'b01; reg_we = 1;
    for (int i = 0; i < 4; i++) begin
      data_gnt = (i == 3);
      #2;
      check("sh_req", 32'(data_req), 32'd1);
      check("sh_addr", data_addr, 32'h200);
      check("sh_be", 32'(data_be), 32'hC);
      check("sh_wdata", data_wdata, 32'hABCD_ABCD);
      check("sh_we", 32'(data_we), 32'd1);
      check("sh_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
      check("sh_wbwe", 32'(wb_we), 32'd0);
      tick();
    end
    clear_inputs();

    // sb and sw with same-cycle grant, back to back
    op_c = 32'h301; mem_wdata = 32'h1234_5677; mem_req = 1; mem_we = 1;
    mem_size = 2'b00; data_gnt = 1; reg_we = 1;
    #2;
    check("sb_be", 32'(data_be), 32'h2);
    check("sb_wdata", data_wdata, 32'h7777_7777);
    check("sb_stall", 32'(stall), 32'd0);
    check("sb_wbwe", 32'(wb_we), 32'd0);
    tick();
    op_c = 32'h30C; mem_wdata = 32'hCAFE_F00D; mem_size = 2'b10;
    #2;
    check("sw_req", 32'(data_req), 32'd1);
    check("sw_addr", data_addr, 32'h30C);
    check("sw_be", 32'(data_be), 32'hF);
    check("sw_wdata", data_wdata, 32'hCAFE_F00D);
    check("sw_stall", 32'(stall), 32'd0);
    tick();
    clear_inputs();

    // misaligned word access
`ifdef MEM_MISALIGN_CHK_EN
    op_c = 32'h101; mem_req = 1; mem_size = 2'b10; reg_we = 1; data_gnt = 1;
    #2;
    check("mis_req", 32'(data_req), 32'd0);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_wbwe", 32'(wb_we), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    tick();
    clear_inputs();
    #2;
    check("mis_pulse_end", 32'(misalign), 32'd0);
    check("mis_idle_stall", 32'(stall), 32'd0);
    tick();
`else
    op_c = 32'h101; mem_req = 1; mem_size = 2'b10;
    #2;
    check("mis_be", 32'(data_be), 32'hF);
    check("mis_flag", 32'(misalign), 32'd0);
    clear_inputs();
    do_load("mislw", 32'h101, 2'b10, 0, 0, 1, 32'h0BAD_F00D, 32'h100, 32'h0BAD_F00D);
    do_load("mislh", 32'h103, 2'b01, 0, 0, 1, 32'hBEEF_0000, 32'h100, 32'hFFFF_BEEF);
`endif

    // reset while waiting for rvalid
    op_c = 32'h600; mem_req = 1; mem_size = 2'b10; reg_we = 1; data_gnt = 1;
    tick();
    data_gnt = 0;
    #2;
    check("rr_resp_stall", 32'(stall), 32'd1);
    rst_n = 0;
    clear_inputs();
    #1;
    check("rr_async_stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1;
    #2;
    check("rr_idle_req", 32'(data_req), 32'd0);
    check("rr_idle_stall", 32'(stall), 32'd0);
    tick();
    op_c = 32'h55; reg_we = 1; data_rvalid = 1; data_rdata = 32'hDEAD_DEAD;
    #2;
    check("rr_late_rvalid_data", wb_wdata, 32'h55);
    check("rr_late_rvalid_stall", 32'(stall), 32'd0);
    tick();
    clear_inputs();
    #2;
    check("rr_final_stall", 32'(stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
